// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and receiver state encoding.
// Used by uart_rx and its synchronizer; the transmitter shares the same constants.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_BIT_IDX_W = 4;

  // Line levels of an 8N1 frame.
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk    - destination clock
//   rst_n  - synchronous active-low reset, both flops load reset_val
//   d      - asynchronous input
//   q      - synchronized output, two cycles behind d
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampling, mid-bit sampling and a valid/ack holding register.
// Ports:
//   USART_Clk  - receiver clock, OVERSAMPLE x baud
//   rst_n      - synchronous active-low reset
//   serin      - asynchronous serial line, idle high
//   DataOut    - received byte, valid while dataValid=1
//   dataValid  - holding register full
//   dataAck    - consumer takes the byte (ignored while dataValid=0)
//   framingErr - one-cycle pulse when the stop bit is sampled low
//   overrunErr - sticky, a byte completed while the holding register was full
//   busy       - receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CTR_W      = 8
) (
  input  logic       USART_Clk,
  input  logic       rst_n,
  input  logic       serin,
  output uart_byte_t DataOut,
  output logic       dataValid,
  input  logic       dataAck,
  output logic       framingErr,
  output logic       overrunErr,
  output logic       busy
);

  localparam logic [CTR_W-1:0] HALF_LAST = CTR_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CTR_W-1:0] BIT_LAST  = CTR_W'(OVERSAMPLE - 1);
  localparam logic [UART_BIT_IDX_W-1:0] LAST_IDX = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

  logic                      rx_s;
  rx_state_e                 state, state_next;
  logic [CTR_W-1:0]          ctr, ctr_next;
  logic [UART_BIT_IDX_W-1:0] bit_idx, bit_idx_next;
  uart_byte_t                shift_reg, shift_next;
  uart_byte_t                data_next;
  logic                      valid_next;
  logic                      ferr_next;
  logic                      oerr_next;
  logic                      busy_next;
  logic                      ack_take;

  // Bring the pin into the clock domain; idle level out of reset avoids a false start.
  uart_sync2 #(
    .RESET_VAL (UART_IDLE_LEVEL)
  ) u_sync (
    .clk   (USART_Clk),
    .rst_n (rst_n),
    .d     (serin),
    .q     (rx_s)
  );

  // State and output registers.
  always_ff @(posedge USART_Clk) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      ctr        <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      DataOut    <= '0;
      dataValid  <= 1'b0;
      framingErr <= 1'b0;
      overrunErr <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      ctr        <= ctr_next;
      bit_idx    <= bit_idx_next;
      shift_reg  <= shift_next;
      DataOut    <= data_next;
      dataValid  <= valid_next;
      framingErr <= ferr_next;
      overrunErr <= oerr_next;
      busy       <= busy_next;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_next   = state;
    ctr_next     = ctr;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    data_next    = DataOut;
    ferr_next    = 1'b0;
    // The ack is applied before any same-cycle completion sees the holding register.
    ack_take     = dataAck && dataValid;
    valid_next   = dataValid && !ack_take;
    oerr_next    = overrunErr && !ack_take;

    case (state)
      RX_IDLE: begin
        if (rx_s == UART_START_LEVEL) begin
          state_next = RX_START;
          ctr_next   = '0;
        end
      end

      // Re-check the line at mid start bit to reject glitches.
      RX_START: begin
        if (ctr == HALF_LAST) begin
          ctr_next = '0;
          if (rx_s == UART_START_LEVEL) begin
            state_next   = RX_DATA;
            bit_idx_next = '0;
          end else begin
            state_next = RX_IDLE;
          end
        end else begin
          ctr_next = ctr + CTR_W'(1);
        end
      end

      // One sample per bit period, LSB first, shifted in from the top.
      RX_DATA: begin
        if (ctr == BIT_LAST) begin
          ctr_next     = '0;
          shift_next   = {rx_s, shift_reg[UART_DATA_BITS-1:1]};
          bit_idx_next = bit_idx + UART_BIT_IDX_W'(1);
          if (bit_idx == LAST_IDX) begin
            state_next = RX_STOP;
          end
        end else begin
          ctr_next = ctr + CTR_W'(1);
        end
      end

      // Return to idle at mid stop bit so a slightly fast transmitter is tolerated.
      RX_STOP: begin
        if (ctr == BIT_LAST) begin
          ctr_next = '0;
          if (rx_s == UART_STOP_LEVEL) begin
            state_next = RX_IDLE;
            if (!valid_next) begin
              data_next  = shift_reg;
              valid_next = 1'b1;
            end else begin
              oerr_next = 1'b1;
            end
          end else begin
            ferr_next  = 1'b1;
            state_next = RX_BREAK;
          end
        end else begin
          ctr_next = ctr + CTR_W'(1);
        end
      end

      // Hold off until the line goes idle so a break yields a single error.
      RX_BREAK: begin
        if (rx_s == UART_IDLE_LEVEL) begin
          state_next = RX_IDLE;
        end
      end

      default: begin
        state_next = RX_IDLE;
        ctr_next   = '0;
      end
    endcase

    busy_next = (state_next != RX_IDLE);
  end

endmodule
